// File: rtl/program_memory_loader.sv
// Program store for the 8-bit CPU: byte-wide load port, CPU reset sequencing, registered fetch.
// Optional: define PROG_CHECKSUM_EN to add the load_checksum output.
module program_memory_loader #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [7:0]  FILL_WORD = 8'hC3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic       load_last,
  input  logic [7:0] load_data,
  output logic       load_ready,
  output logic       load_done,
  output logic [8:0] load_count,
  output logic       cpu_reset,
`ifdef PROG_CHECKSUM_EN
  output logic [7:0] load_checksum,
`endif
  input  logic [7:0] instruction_address,
  output logic [7:0] instruction
);

  localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0]  DepthW = 9'(DEPTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [8:0]      count_q, count_d;
  logic [7:0]      instr_q, instr_d;
  logic [7:0]      mem [DEPTH];
  logic            beat;
  logic            restart;
  logic            addr_ok;

  assign beat    = load_valid && (state_q == StLoad);
  // load_start is only honoured outside LOAD
  assign restart = load_start && (state_q != StLoad);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    case (state_q)
      StIdle, StRun: begin
        if (load_start) begin
          state_d = StLoad;
          ptr_d   = '0;
          count_d = '0;
        end
      end
      StLoad: begin
        if (load_valid) begin
          ptr_d   = ptr_q + PtrW'(1);
          count_d = count_q + 9'd1;
          if (load_last || (ptr_q == PtrW'(DEPTH - 1))) begin
            state_d = StRun;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately not reset; stale words stay hidden behind load_count.
  always_ff @(posedge clock) begin
    if (beat) begin
      mem[ptr_q] <= load_data;
    end
  end

  always_comb begin
    addr_ok = ({1'b0, instruction_address} < count_q) &&
              ({1'b0, instruction_address} < DepthW);
    instr_d = addr_ok ? mem[instruction_address[PtrW-1:0]] : FILL_WORD;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instr_q <= FILL_WORD;
    end else begin
      instr_q <= instr_d;
    end
  end

`ifdef PROG_CHECKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else if (restart) begin
      sum_q <= '0;
    end else if (beat) begin
      sum_q <= sum_q + load_data;
    end
  end

  assign load_checksum = sum_q;
`endif

  assign load_ready  = (state_q == StLoad);
  assign load_done   = (state_q == StRun);
  assign cpu_reset   = (state_q != StRun);
  assign load_count  = count_q;
  assign instruction = instr_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// Self-checking bench for program_memory_loader: reference model plus fetch scoreboard.
// Also covers load_checksum when PROG_CHECKSUM_EN is defined.
module tb_program_memory_loader;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       load_start;
  logic       load_valid;
  logic       load_last;
  logic [7:0] load_data;
  logic       load_ready;
  logic       load_done;
  logic [8:0] load_count;
  logic       cpu_reset;
  logic [7:0] instruction_address;
  logic [7:0] instruction;
`ifdef PROG_CHECKSUM_EN
  logic [7:0] load_checksum;
`endif

  program_memory_loader #(
    .DEPTH     (256),
    .FILL_WORD (8'hC3)
  ) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .load_start          (load_start),
    .load_valid          (load_valid),
    .load_last           (load_last),
    .load_data           (load_data),
    .load_ready          (load_ready),
    .load_done           (load_done),
    .load_count          (load_count),
    .cpu_reset           (cpu_reset),
`ifdef PROG_CHECKSUM_EN
    .load_checksum       (load_checksum),
`endif
    .instruction_address (instruction_address),
    .instruction         (instruction)
  );

  always #5 clock = ~clock;

  localparam int MIdle = 0;
  localparam int MLoad = 1;
  localparam int MRun  = 2;

  int         n_checks = 0;
  int         n_errors = 0;
  int         m_state  = MIdle;
  int         m_ptr    = 0;
  int         m_count  = 0;
  logic [7:0] m_sum    = 8'h00;
  logic [7:0] model_mem [256];
  logic [7:0] exp_q [$];
  logic [7:0] img [256];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [7:0] exp_fetch(input int a);
    return (a < m_count) ? model_mem[a] : 8'hC3;
  endfunction

  task automatic check_state(input string tag);
    check_eq({tag, ".ready"}, 32'(load_ready), 32'(m_state == MLoad));
    check_eq({tag, ".done"}, 32'(load_done), 32'(m_state == MRun));
    check_eq({tag, ".cpu_reset"}, 32'(cpu_reset), 32'(m_state != MRun));
    check_eq({tag, ".count"}, 32'(load_count), 32'(m_count));
`ifdef PROG_CHECKSUM_EN
    check_eq({tag, ".checksum"}, 32'(load_checksum), 32'(m_sum));
`endif
  endtask

  task automatic start();
    load_start = 1'b1;
    if (m_state != MLoad) begin
      m_state = MLoad;
      m_ptr   = 0;
      m_count = 0;
      m_sum   = 8'h00;
    end
    step();
    load_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    if (m_state == MLoad) begin
      model_mem[m_ptr] = d;
      m_count++;
      m_sum = m_sum + d;
      if (last || m_ptr == 255) m_state = MRun;
      m_ptr = (m_ptr + 1) % 256;
    end
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic idle_cycle(input logic last);
    load_valid = 1'b0;
    load_last  = last;
    load_data  = 8'hEE;
    step();
    load_last  = 1'b0;
  endtask

  task automatic fetch(input string tag, input int a);
    instruction_address = 8'(a);
    exp_q.push_back(exp_fetch(a));
    step();
    check_eq(tag, 32'(instruction), 32'(exp_q.pop_front()));
  endtask

  initial begin
    reset_n = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last = 1'b0;
    load_data = 8'h00;
    instruction_address = 8'h00;
    @(negedge clock);
    @(negedge clock);

    // 1: reset values
    check_eq("rst.cpu_reset", 32'(cpu_reset), 32'd1);
    check_eq("rst.ready", 32'(load_ready), 32'd0);
    check_eq("rst.done", 32'(load_done), 32'd0);
    check_eq("rst.count", 32'(load_count), 32'd0);
    check_eq("rst.instr", 32'(instruction), 32'hC3);
    reset_n = 1'b1;
    step();
    send(8'h11, 1'b1);  // ignored in IDLE
    check_state("idle_valid");
    fetch("idle.f0", 0);

    // 2: three-byte image
    start();
    check_state("t2.loading");
    send(8'h05, 1'b0);
    send(8'h46, 1'b0);
    send(8'hC3, 1'b1);
    check_state("t2.run");
    check_eq("t2.count", 32'(load_count), 32'd3);
    check_eq("t2.cpu_reset", 32'(cpu_reset), 32'd0);
    fetch("t2.f1", 1);
    check_eq("t2.f1_const", 32'(instruction), 32'h46);
    fetch("t2.f3", 3);
    fetch("t2.f0", 0);
    send(8'h77, 1'b0);  // ignored in RUN
    check_state("t2.run_valid");
    fetch("t2.f0b", 0);

    // 3: stalls, load_last without valid, load_start in LOAD
    start();
    send(8'hAA, 1'b0);
    check_state("t3.b1");
    idle_cycle(1'b1);
    check_state("t3.gap1");
    load_start = 1'b1;
    idle_cycle(1'b0);
    load_start = 1'b0;
    check_state("t3.gap2");
    send(8'hBB, 1'b0);
    check_state("t3.b2");
    check_eq("t3.count2", 32'(load_count), 32'd2);
    send(8'hCC, 1'b1);
    check_state("t3.run");
    for (int a = 0; a < 4; a++) fetch($sformatf("t3.f%0d", a), a);

    // 4: full 256-byte image ends without load_last
    start();
    for (int i = 0; i < 256; i++) img[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 255; i++) send(img[i], 1'b0);
    check_state("t4.b255");
    send(img[255], 1'b0);
    check_state("t4.run");
    check_eq("t4.count", 32'(load_count), 32'd256);
    fetch("t4.fFF", 255);
    check_eq("t4.fFF_const", 32'(instruction), 32'(img[255]));
    fetch("t4.f00", 0);
    fetch("t4.f80", 128);

    // 5: restart from RUN, one-byte image, async reset mid-load
    start();
    check_state("t5.restart");
    check_eq("t5.cpu_reset", 32'(cpu_reset), 32'd1);
    send(8'h00, 1'b1);
    check_state("t5.run");
    fetch("t5.f1", 1);
    fetch("t5.f0", 0);
    start();
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    reset_n = 1'b0;
    #1;
    m_state = MIdle;
    m_count = 0;
    m_sum   = 8'h00;
    check_state("t5.async_rst");
    check_eq("t5.rst_instr", 32'(instruction), 32'hC3);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    check_state("t5.idle");
    fetch("t5.f0_after", 0);

`ifdef PROG_CHECKSUM_EN
    // 6: checksum
    start();
    send(8'h80, 1'b0);
    send(8'h90, 1'b0);
    send(8'hF0, 1'b1);
    check_eq("t6.sum1", 32'(load_checksum), 32'h00);
    check_state("t6.run");
    start();
    check_eq("t6.cleared", 32'(load_checksum), 32'h00);
    send(8'h01, 1'b1);
    check_eq("t6.sum2", 32'(load_checksum), 32'h01);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
